// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier X shift register.
package booth_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int SEL_W = 3;
endpackage

// File: rtl/booth_step_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module booth_step_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/booth_multiplier_shreg.sv
// Multiplier (X) shift register for the Booth datapath: holds X and Q(-1),
// shifts in accumulator LSBs, and presents radix-2/radix-4 selector bits.
module booth_multiplier_shreg
    import booth_pkg::*;
#(
    parameter int W         = 8,
    parameter int RADIX4_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           x_in,
    input  logic                   mode_r4,
    input  logic                   ldx,
    input  logic                   shrx,
    input  logic [1:0]             s_in,
    output logic [W-1:0]           x_out,
    output logic [1:0]             s_out,
    output logic [SEL_W-1:0]       booth_sel,
    output logic                   x_zero,
    output logic [$clog2(W+1)-1:0] cnt,
    output logic                   busy,
    output logic                   done
);
    localparam int CW = $clog2(W+1);

    if ((RADIX4_EN != 0) && ((W % 2) != 0)) begin : g_bad_width
        $error("booth_multiplier_shreg: W must be even when RADIX4_EN=1");
    end

    state_e        state_q, state_d;
    logic [W-1:0]  x_q, x_d;
    logic          q_m1_q, q_m1_d;
    logic [1:0]    s_q, s_d;
    logic          mode_q, mode_d;
    logic          step;
    logic          cnt_zero;
    logic [CW-1:0] cnt_load_val;

    assign cnt_load_val = (mode_r4 && (RADIX4_EN != 0)) ? CW'(W / 2) : CW'(W);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        q_m1_d  = q_m1_q;
        s_d     = s_q;
        mode_d  = mode_q;
        step    = 1'b0;
        if (ldx) begin
            x_d     = x_in;
            q_m1_d  = 1'b0;
            s_d     = 2'b00;
            mode_d  = mode_r4 && (RADIX4_EN != 0);
            state_d = ST_SHIFT;
        end else if (shrx && (state_q == ST_SHIFT) && !cnt_zero) begin
            step = 1'b1;
            if (mode_q) begin
                x_d    = {s_in, x_q[W-1:2]};
                q_m1_d = x_q[1];
                s_d    = x_q[1:0];
            end else begin
                x_d    = {s_in[0], x_q[W-1:1]};
                q_m1_d = x_q[0];
                s_d    = {1'b0, x_q[0]};
            end
            // Final step: the counter is about to reach zero on this edge.
            if (cnt == CW'(1)) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            q_m1_q  <= 1'b0;
            s_q     <= 2'b00;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            q_m1_q  <= q_m1_d;
            s_q     <= s_d;
            mode_q  <= mode_d;
        end
    end

    booth_step_counter #(.CW(CW)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ldx),
        .load_val_i (cnt_load_val),
        .dec_i      (step),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    assign x_out     = x_q;
    assign s_out     = s_q;
    assign booth_sel = mode_q ? {x_q[1:0], q_m1_q} : {1'b0, x_q[0], q_m1_q};
    assign x_zero    = x_q[0];
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
endmodule

// File: tb/tb_booth_multiplier_shreg.sv
// Scoreboard bench: two instances (radix-4 enabled / disabled) share stimulus;
// an arithmetic reference model pushes expectations, a monitor pops and compares.
module tb_booth_multiplier_shreg;
    localparam int W = 8;

    typedef struct {
        logic [7:0] x;
        logic [1:0] s;
        logic [2:0] sel;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] x_in = '0;
    logic       mode_r4 = 1'b0;
    logic       ldx = 1'b0;
    logic       shrx = 1'b0;
    logic [1:0] s_in = '0;

    logic [7:0] x_out [2];
    logic [1:0] s_out [2];
    logic [2:0] booth_sel [2];
    logic       x_zero [2];
    logic [3:0] cnt [2];
    logic       busy [2];
    logic       done [2];

    int checks = 0;
    int failures = 0;

    exp_t exp_q [2][$];

    // Reference state: index 0 = radix-4 capable, index 1 = radix-2 only
    int m_x [2];
    int m_q [2];
    int m_s [2];
    int m_cnt [2];
    int m_mode [2];
    int m_st [2];   // 0 idle, 1 shifting, 2 done

    always #5 clk = ~clk;

    booth_multiplier_shreg #(.W(W), .RADIX4_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .mode_r4(mode_r4), .ldx(ldx),
        .shrx(shrx), .s_in(s_in), .x_out(x_out[0]), .s_out(s_out[0]),
        .booth_sel(booth_sel[0]), .x_zero(x_zero[0]), .cnt(cnt[0]),
        .busy(busy[0]), .done(done[0])
    );

    booth_multiplier_shreg #(.W(W), .RADIX4_EN(0)) dut_r2 (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .mode_r4(mode_r4), .ldx(ldx),
        .shrx(shrx), .s_in(s_in), .x_out(x_out[1]), .s_out(s_out[1]),
        .booth_sel(booth_sel[1]), .x_zero(x_zero[1]), .cnt(cnt[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_x[k] = 0; m_q[k] = 0; m_s[k] = 0; m_cnt[k] = 0; m_mode[k] = 0; m_st[k] = 0;
        end
    endtask

    function automatic exp_t model_view(input int k);
        exp_t e;
        int sel;
        sel = m_mode[k] != 0 ? (m_x[k] % 4) * 2 + m_q[k] : (m_x[k] % 2) * 2 + m_q[k];
        e.x = 8'(m_x[k]); e.s = 2'(m_s[k]); e.sel = 3'(sel); e.cnt = 4'(m_cnt[k]);
        e.busy = (m_st[k] == 1); e.done = (m_st[k] == 2);
        return e;
    endfunction

    task automatic model_edge(input bit l, input bit sh, input int si, input int xi, input bit md);
        for (int k = 0; k < 2; k++) begin
            if (l) begin
                m_x[k] = xi; m_q[k] = 0; m_s[k] = 0;
                m_mode[k] = (md && k == 0) ? 1 : 0;
                m_cnt[k] = m_mode[k] != 0 ? W / 2 : W;
                m_st[k] = 1;
            end else if (sh && m_st[k] == 1) begin
                if (m_mode[k] != 0) begin
                    m_s[k] = m_x[k] % 4;
                    m_q[k] = (m_x[k] / 2) % 2;
                    m_x[k] = m_x[k] / 4 + si * 64;
                end else begin
                    m_s[k] = m_x[k] % 2;
                    m_q[k] = m_x[k] % 2;
                    m_x[k] = m_x[k] / 2 + (si % 2) * 128;
                end
                m_cnt[k] = m_cnt[k] - 1;
                if (m_cnt[k] == 0) m_st[k] = 2;
            end
        end
    endtask

    // Inputs are applied just after a rising edge; expectations are pushed
    // just after the edge that consumes them, so the monitor sees settled outputs.
    task automatic step(input bit l, input bit sh, input int si, input int xi, input bit md);
        ldx = l; shrx = sh; s_in = 2'(si); x_in = 8'(xi); mode_r4 = md;
        model_edge(l, sh, si, xi, md);
        @(posedge clk); #1;
        ldx = 1'b0; shrx = 1'b0;
        for (int k = 0; k < 2; k++) exp_q[k].push_back(model_view(k));
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (exp_q[k].size() > 0) begin
                exp_t e;
                e = exp_q[k].pop_front();
                check($sformatf("x_out[%0d]", k), int'(x_out[k]), int'(e.x));
                check($sformatf("s_out[%0d]", k), int'(s_out[k]), int'(e.s));
                check($sformatf("booth_sel[%0d]", k), int'(booth_sel[k]), int'(e.sel));
                check($sformatf("x_zero[%0d]", k), int'(x_zero[k]), int'(e.x[0]));
                check($sformatf("cnt[%0d]", k), int'(cnt[k]), int'(e.cnt));
                check($sformatf("busy[%0d]", k), int'(busy[k]), int'(e.busy));
                check($sformatf("done[%0d]", k), int'(done[k]), int'(e.done));
            end
        end
    end

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_x_out", int'(x_out[0]), 0);
        check("reset_cnt", int'(cnt[0]), 0);
        check("reset_busy_done", int'({busy[0], done[0]}), 0);

        // Radix-2 load and step
        step(1, 0, 0, 'hB5, 0);
        @(negedge clk); #1;
        check("r2_load_sel", int'(booth_sel[0]), 'b010);
        check("r2_load_cnt", int'(cnt[0]), 8);
        step(0, 1, 0, 0, 0);
        @(negedge clk); #1;
        check("r2_step_x", int'(x_out[0]), 'h5A);
        check("r2_step_sel", int'(booth_sel[0]), 'b001);
        check("r2_step_s", int'(s_out[0]), 'b01);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
        @(negedge clk); #1;
        check("r2_done", int'({done[0], cnt[0]}), 'h10);

        // In DONE, shrx is ignored
        for (int i = 0; i < 3; i++) step(0, 1, 3, 0, 0);

        // Radix-4 load and step (dut_r2 must stay radix-2)
        step(1, 0, 0, 'h5A, 1);
        @(negedge clk); #1;
        check("r4_load_sel", int'(booth_sel[0]), 'b100);
        check("r4_load_cnt", int'(cnt[0]), 4);
        check("r2only_load_cnt", int'(cnt[1]), 8);
        step(0, 1, 3, 0, 0);
        @(negedge clk); #1;
        check("r4_step_x", int'(x_out[0]), 'hD6);
        check("r4_step_sel", int'(booth_sel[0]), 'b101);
        check("r4_step_s", int'(s_out[0]), 'b10);
        for (int i = 0; i < 3; i++) step(0, 1, $urandom_range(0, 3), 0, 0);
        @(negedge clk); #1;
        check("r4_done", int'(done[0]), 1);

        // Reload wins over shift mid-sequence
        step(1, 0, 0, 'h3C, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        step(1, 1, 2, 'hC3, 0);
        @(negedge clk); #1;
        check("reload_x", int'(x_out[0]), 'hC3);
        check("reload_cnt", int'(cnt[0]), 8);

        // Async reset mid-shift (cnt=5)
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_x", int'(x_out[0]), 0);
        check("async_rst_cnt", int'(cnt[0]), 0);
        check("async_rst_busy", int'(busy[0]), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(0, 1, 3, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 1));
        end

        @(negedge clk); #1;
        check("scoreboard_drained", exp_q[0].size() + exp_q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
